// File: rtl/rdma_pkg.sv
// rtl/rdma_pkg.sv - shared types and field offsets for the SQ fetch command generator
//
// Purpose : FSM state encoding, DataMover command field offsets and
//           status_word bit indices shared by sq_fetch_cmd_gen and dm_cmd_pack.
// Ports   : none (package).
package rdma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_CMPLT = 2'd2,
      ST_CFG_ERR    = 2'd3
   } sq_state_t;

   // DataMover MM2S command layout (72 bits)
   localparam int CMD_W        = 72;
   localparam int CMD_BTT_LSB  = 0;
   localparam int CMD_BTT_W    = 23;
   localparam int CMD_TYPE_BIT = 23;
   localparam int CMD_DSA_LSB  = 24;
   localparam int CMD_EOF_BIT  = 30;
   localparam int CMD_DRR_BIT  = 31;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_TAG_LSB  = 64;
   localparam int CMD_TAG_W    = 4;
   localparam int CMD_RSVD_LSB = 68;

   localparam logic DM_TYPE_INCR = 1'b1;

   // status_word layout
   localparam int STS_HEAD_LSB    = 0;
   localparam int STS_TAIL_LSB    = 4;
   localparam int STS_STATE_LSB   = 8;
   localparam int STS_CFG_ERR_BIT = 10;
   localparam int STS_SPUR_BIT    = 11;
   localparam int STS_DM_ERR_BIT  = 12;
   localparam int STS_CNT_LSB     = 16;

endpackage

// File: rtl/dm_cmd_pack.sv
// rtl/dm_cmd_pack.sv - combinational packer for the 72-bit DataMover MM2S command
//
// Purpose : map (addr, btt, tag) onto the command word; INCR burst, EOF set,
//           DSA/DRR/reserved zero.
// Ports   : addr [31:0] in  - transfer start byte address
//           btt  [22:0] in  - bytes to transfer
//           tag  [3:0]  in  - command tag
//           cmd  [71:0] out - packed command
module dm_cmd_pack
   import rdma_pkg::*;
(
   input  logic [31:0]          addr,
   input  logic [CMD_BTT_W-1:0] btt,
   input  logic [CMD_TAG_W-1:0] tag,
   output logic [CMD_W-1:0]     cmd
);

   always_comb begin
      cmd                             = '0;
      cmd[CMD_BTT_LSB +: CMD_BTT_W]   = btt;
      cmd[CMD_TYPE_BIT]               = DM_TYPE_INCR;
      cmd[CMD_EOF_BIT]                = 1'b1;
      cmd[CMD_ADDR_LSB +: 32]         = addr;
      cmd[CMD_TAG_LSB +: CMD_TAG_W]   = tag;
   end

endmodule

// File: rtl/sq_fetch_cmd_gen.sv
// rtl/sq_fetch_cmd_gen.sv - submission-queue entry fetch command generator
//
// Purpose : walks the SQ ring from hw_sq_head towards sq_tail, issuing one
//           DataMover MM2S read command per entry and advancing the head on
//           each read-done pulse.
// Config  : define SQ_FETCH_STS_EN to add the MM2S status stream; a status
//           with any of bits [6:4] set flags dm_err and parks in CFG_ERR.
// Ports   : clk, rst_n (async, active-low)
//           global_enable         in  - run enable
//           sq_base/sq_size/sq_tail in - ring configuration and producer index
//           hw_sq_head            out - consumer index
//           m_axis_mm2s_cmd_*     - command stream (tdata/tvalid/tready)
//           mm2s_rd_xfer_cmplt    in  - read-done pulse
//           s_axis_mm2s_sts_*     - status stream (SQ_FETCH_STS_EN only)
//           cmd_ctrl_ready        out - high in IDLE
//           wqe_processed         out - completed-entry counter
//           status_word           out - debug status
module sq_fetch_cmd_gen
   import rdma_pkg::*;
#(
   parameter int WQE_BYTES = 64,
   parameter int SQ_IDX_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                global_enable,
   input  logic [31:0]         sq_base,
   input  logic [SQ_IDX_W:0]   sq_size,
   input  logic [SQ_IDX_W-1:0] sq_tail,
   output logic [SQ_IDX_W-1:0] hw_sq_head,
   output logic [CMD_W-1:0]    m_axis_mm2s_cmd_tdata,
   output logic                m_axis_mm2s_cmd_tvalid,
   input  logic                m_axis_mm2s_cmd_tready,
   input  logic                mm2s_rd_xfer_cmplt,
`ifdef SQ_FETCH_STS_EN
   input  logic [7:0]          s_axis_mm2s_sts_tdata,
   input  logic                s_axis_mm2s_sts_tvalid,
   output logic                s_axis_mm2s_sts_tready,
`endif
   output logic                cmd_ctrl_ready,
   output logic [31:0]         wqe_processed,
   output logic [31:0]         status_word
);

   localparam logic [SQ_IDX_W:0] SIZE_MIN = (SQ_IDX_W+1)'(2);
   localparam logic [SQ_IDX_W:0] SIZE_MAX = {1'b1, {SQ_IDX_W{1'b0}}};
   localparam logic [SQ_IDX_W:0] ONE      = (SQ_IDX_W+1)'(1);

   sq_state_t           state, state_nxt;
   logic [CMD_W-1:0]    cmd_nxt;
   logic [31:0]         addr;
   logic [SQ_IDX_W:0]   head_inc;
   logic [SQ_IDX_W-1:0] head_wrap;
   logic                pending, cfg_ok, dm_fail, cmplt_ok;
   logic                cfg_err, spurious_cmplt, dm_err;

   assign pending   = global_enable && (hw_sq_head != sq_tail);
   assign cfg_ok    = (sq_size >= SIZE_MIN) && (sq_size <= SIZE_MAX) &&
                      ({1'b0, sq_tail} < sq_size);
   assign addr      = sq_base + 32'(hw_sq_head) * 32'(WQE_BYTES);
   assign head_inc  = {1'b0, hw_sq_head} + ONE;
   assign head_wrap = (head_inc == sq_size) ? '0 : head_inc[SQ_IDX_W-1:0];

`ifdef SQ_FETCH_STS_EN
   logic unused_sts;
   assign unused_sts             = ^{s_axis_mm2s_sts_tdata[7], s_axis_mm2s_sts_tdata[3:0]};
   assign s_axis_mm2s_sts_tready = 1'b1;
   assign dm_fail = (state == ST_WAIT_CMPLT) && s_axis_mm2s_sts_tvalid &&
                    (|s_axis_mm2s_sts_tdata[6:4]);
`else
   assign dm_fail = 1'b0;
`endif

   // A failing status wins over a same-cycle read-done: the entry is not consumed.
   assign cmplt_ok = (state == ST_WAIT_CMPLT) && mm2s_rd_xfer_cmplt && !dm_fail;

   dm_cmd_pack u_pack (
      .addr (addr),
      .btt  (CMD_BTT_W'(WQE_BYTES)),
      .tag  (CMD_TAG_W'(hw_sq_head)),
      .cmd  (cmd_nxt)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (pending) state_nxt = cfg_ok ? ST_ISSUE : ST_CFG_ERR;
         ST_ISSUE:      if (m_axis_mm2s_cmd_tready) state_nxt = ST_WAIT_CMPLT;
         ST_WAIT_CMPLT: begin
            if (dm_fail)       state_nxt = ST_CFG_ERR;
            else if (cmplt_ok) state_nxt = ST_IDLE;
         end
         ST_CFG_ERR:    if (!global_enable) state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      m_axis_mm2s_cmd_tvalid = (state == ST_ISSUE);
      cmd_ctrl_ready         = (state == ST_IDLE);
   end

   // datapath: command is latched on entry to ISSUE so it stays stable under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_mm2s_cmd_tdata <= '0;
         hw_sq_head            <= '0;
         wqe_processed         <= '0;
         cfg_err               <= 1'b0;
         spurious_cmplt        <= 1'b0;
      end else begin
         if (state == ST_IDLE && pending && cfg_ok) m_axis_mm2s_cmd_tdata <= cmd_nxt;
         if (state == ST_IDLE && pending && !cfg_ok) cfg_err <= 1'b1;
         if (cmplt_ok) begin
            hw_sq_head    <= head_wrap;
            wqe_processed <= wqe_processed + 32'd1;
         end
         if (mm2s_rd_xfer_cmplt && state != ST_WAIT_CMPLT) spurious_cmplt <= 1'b1;
      end
   end

`ifdef SQ_FETCH_STS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       dm_err <= 1'b0;
      else if (dm_fail) dm_err <= 1'b1;
   end
`else
   assign dm_err = 1'b0;
`endif

   always_comb begin
      status_word                         = '0;
      status_word[STS_HEAD_LSB +: 4]      = 4'(hw_sq_head);
      status_word[STS_TAIL_LSB +: 4]      = 4'(sq_tail);
      status_word[STS_STATE_LSB +: 2]     = state;
      status_word[STS_CFG_ERR_BIT]        = cfg_err;
      status_word[STS_SPUR_BIT]           = spurious_cmplt;
      status_word[STS_DM_ERR_BIT]         = dm_err;
      status_word[STS_CNT_LSB +: 16]      = wqe_processed[15:0];
   end

endmodule

// File: tb/tb_sq_fetch_cmd_gen.sv
// tb/tb_sq_fetch_cmd_gen.sv - self-checking bench for sq_fetch_cmd_gen
module tb_sq_fetch_cmd_gen;

   logic        clk = 1'b0;
   logic        rst_n, global_enable;
   logic [31:0] sq_base;
   logic [4:0]  sq_size;
   logic [3:0]  sq_tail, hw_sq_head;
   logic [71:0] tdata;
   logic        tvalid, tready, cmplt, cmd_ctrl_ready;
   logic [31:0] wqe_processed, status_word;
`ifdef SQ_FETCH_STS_EN
   logic [7:0]  sts_tdata;
   logic        sts_tvalid, sts_tready;
`endif

   int total = 0;
   int bad   = 0;

   logic [3:0]  m_head;
   logic [31:0] m_cnt;
   logic        m_cfg, m_spur, m_dm;

   always #5 clk = ~clk;

   sq_fetch_cmd_gen #(.WQE_BYTES(64), .SQ_IDX_W(4)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .global_enable          (global_enable),
      .sq_base                (sq_base),
      .sq_size                (sq_size),
      .sq_tail                (sq_tail),
      .hw_sq_head             (hw_sq_head),
      .m_axis_mm2s_cmd_tdata  (tdata),
      .m_axis_mm2s_cmd_tvalid (tvalid),
      .m_axis_mm2s_cmd_tready (tready),
      .mm2s_rd_xfer_cmplt     (cmplt),
`ifdef SQ_FETCH_STS_EN
      .s_axis_mm2s_sts_tdata  (sts_tdata),
      .s_axis_mm2s_sts_tvalid (sts_tvalid),
      .s_axis_mm2s_sts_tready (sts_tready),
`endif
      .cmd_ctrl_ready         (cmd_ctrl_ready),
      .wqe_processed          (wqe_processed),
      .status_word            (status_word)
   );

   function automatic logic [71:0] exp_cmd(input logic [31:0] base, input logic [3:0] idx);
      logic [31:0] a;
      a = base + {28'd0, idx} * 32'd64;
      return {4'h0, idx, a, 1'b0, 1'b1, 6'd0, 1'b1, 23'd64};
   endfunction

   function automatic logic [31:0] exp_status(input logic [1:0] st);
      return {m_cnt[15:0], 3'b000, m_dm, m_spur, m_cfg, st, sq_tail, m_head};
   endfunction

   function automatic logic [3:0] next_head(input logic [3:0] h, input logic [4:0] size);
      int n;
      n = (int'(h) + 1) % int'(size);
      return 4'(n);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one full command/complete exchange; no checking here.
   task automatic run_txn(input int rdy_wait, input int cmplt_wait,
                          output logic [71:0] cmd, output int hs,
                          output bit stable, output bit tmo, output bit head_held);
      logic [3:0] h0;
      hs = 0; stable = 1'b1; tmo = 1'b0; head_held = 1'b1; cmd = '0;
      for (int i = 0; i < 20 && !tvalid; i++) step();
      if (!tvalid) begin
         tmo = 1'b1;
         return;
      end
      h0  = hw_sq_head;
      cmd = tdata;
      for (int i = 0; i < rdy_wait; i++) begin
         step();
         if (!tvalid || tdata !== cmd) stable = 1'b0;
      end
      tready = 1'b1;
      if (tvalid) hs++;
      step();
      tready = 1'b0;
      for (int i = 0; i <= cmplt_wait; i++) begin
         if (tvalid) hs++;
         if (hw_sq_head !== h0) head_held = 1'b0;
         step();
      end
      cmplt = 1'b1;
      step();
      cmplt = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (hw_sq_head !== 4'd0 || tvalid !== 1'b0 || tdata !== 72'd0 ||
          wqe_processed !== 32'd0 || cmd_ctrl_ready !== 1'b1 || status_word !== 32'd0) begin
         bad++;
         $display("FAIL reset: head=%0d tvalid=%0b tdata=%h cnt=%0d ready=%0b sw=%h expected zeros, ready=1",
                  hw_sq_head, tvalid, tdata, wqe_processed, cmd_ctrl_ready, status_word);
      end
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [71:0] c; int hs; bit st, tmo, hh;
      sq_base = 32'h1000_0000; sq_size = 5'd8; sq_tail = 4'd1; global_enable = 1'b1;
      run_txn(0, 2, c, hs, st, tmo, hh);
      total++;
      if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: no tvalid"); end
      total++;
      if (c !== exp_cmd(32'h1000_0000, 4'd0)) begin
         bad++; $display("FAIL basic_cmd: got %h want %h", c, exp_cmd(32'h1000_0000, 4'd0));
      end
      total++;
      if (hh !== 1'b1 || hs !== 1) begin
         bad++; $display("FAIL basic_hold: head_held=%0b hs=%0d want 1/1", hh, hs);
      end
      m_head = 4'd1; m_cnt = 32'd1;
      total++;
      if (hw_sq_head !== 4'd1 || wqe_processed !== 32'd1 || status_word !== exp_status(2'd0)) begin
         bad++; $display("FAIL basic_after: head=%0d cnt=%0d sw=%h want 1 1 %h",
                         hw_sq_head, wqe_processed, status_word, exp_status(2'd0));
      end
   endtask

   task automatic test_backpressure();
      logic [71:0] c; int hs; bit st, tmo, hh;
      sq_tail = 4'd2;
      run_txn(5, 1, c, hs, st, tmo, hh);
      total++;
      if (tmo !== 1'b0 || st !== 1'b1 || hs !== 1) begin
         bad++; $display("FAIL bp_stable: tmo=%0b stable=%0b hs=%0d want 0 1 1", tmo, st, hs);
      end
      total++;
      if (c !== exp_cmd(sq_base, 4'd1)) begin
         bad++; $display("FAIL bp_cmd: got %h want %h", c, exp_cmd(sq_base, 4'd1));
      end
      m_head = 4'd2; m_cnt++;
      total++;
      if (hw_sq_head !== m_head || wqe_processed !== m_cnt) begin
         bad++; $display("FAIL bp_after: head=%0d cnt=%0d want %0d %0d", hw_sq_head, wqe_processed, m_head, m_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [71:0] c; int hs; bit st, tmo, hh;
      sq_tail = 4'd7;
      for (int i = 0; i < 10 && m_head != 4'd7; i++) begin
         run_txn(0, 0, c, hs, st, tmo, hh);
         total++;
         if (c !== exp_cmd(sq_base, m_head) || tmo) begin
            bad++; $display("FAIL wrap_walk: got %h want %h tmo=%0b", c, exp_cmd(sq_base, m_head), tmo);
         end
         m_head = next_head(m_head, sq_size); m_cnt++;
      end
      sq_tail = 4'd0;
      run_txn(1, 1, c, hs, st, tmo, hh);
      total++;
      if (c[63:32] !== 32'h1000_01C0 || c[67:64] !== 4'd7) begin
         bad++; $display("FAIL wrap_addr: addr=%h tag=%0d want 100001c0 7", c[63:32], c[67:64]);
      end
      m_head = 4'd0; m_cnt++;
      total++;
      if (hw_sq_head !== 4'd0 || wqe_processed !== m_cnt) begin
         bad++; $display("FAIL wrap_head: head=%0d cnt=%0d want 0 %0d", hw_sq_head, wqe_processed, m_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [71:0] c; int hs; bit st, tmo, hh;
      sq_tail = 4'd2;
      run_txn(0, 0, c, hs, st, tmo, hh);
      m_head = 4'd1; m_cnt++;
      step();
      total++;
      if (tvalid !== 1'b1 || tdata !== exp_cmd(sq_base, 4'd1)) begin
         bad++; $display("FAIL b2b_issue: tvalid=%0b tdata=%h want 1 %h", tvalid, tdata, exp_cmd(sq_base, 4'd1));
      end
      run_txn(0, 0, c, hs, st, tmo, hh);
      m_head = 4'd2; m_cnt++;
      total++;
      if (hw_sq_head !== m_head || wqe_processed !== m_cnt) begin
         bad++; $display("FAIL b2b_after: head=%0d cnt=%0d want %0d %0d", hw_sq_head, wqe_processed, m_head, m_cnt);
      end
   endtask

   task automatic test_spurious();
      cmplt = 1'b1;
      step();
      cmplt = 1'b0;
      m_spur = 1'b1;
      total++;
      if (hw_sq_head !== m_head || status_word[11] !== 1'b1 || status_word !== exp_status(2'd0)) begin
         bad++; $display("FAIL spurious: head=%0d sw=%h want %0d %h", hw_sq_head, status_word, m_head, exp_status(2'd0));
      end
   endtask

   task automatic test_cfg_err();
      int seen = 0;
      sq_size = 5'd1; sq_tail = 4'd3;
      step(); step();
      m_cfg = 1'b1;
      total++;
      if (status_word !== exp_status(2'd3) || status_word[10] !== 1'b1 || cmd_ctrl_ready !== 1'b0) begin
         bad++; $display("FAIL cfg_err_state: sw=%h ready=%0b want %h 0", status_word, cmd_ctrl_ready, exp_status(2'd3));
      end
      for (int i = 0; i < 4; i++) begin
         if (tvalid) seen++;
         step();
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL cfg_err_nocmd: tvalid cycles=%0d want 0", seen); end
      global_enable = 1'b0;
      step();
      total++;
      if (cmd_ctrl_ready !== 1'b1 || status_word[9:8] !== 2'd0) begin
         bad++; $display("FAIL cfg_err_exit: ready=%0b state=%0d want 1 0", cmd_ctrl_ready, status_word[9:8]);
      end
      sq_size = 5'd8; sq_tail = m_head;
      global_enable = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [71:0] c; int hs; bit st, tmo, hh;
      int lo;
      for (int it = 0; it < 12; it++) begin
         lo = (int'(m_head) + 1 < 2) ? 2 : int'(m_head) + 1;
         sq_size = 5'($urandom_range(16, lo));
         sq_base = $urandom;
         sq_tail = 4'((int'(m_head) + int'($urandom_range(int'(sq_size) - 1, 1))) % int'(sq_size));
         for (int k = 0; k < 17 && m_head != sq_tail; k++) begin
            run_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), c, hs, st, tmo, hh);
            total++;
            if (tmo || hs !== 1 || !hh || c !== exp_cmd(sq_base, m_head)) begin
               bad++; $display("FAIL rand_cmd: tmo=%0b hs=%0d held=%0b got %h want %h",
                               tmo, hs, hh, c, exp_cmd(sq_base, m_head));
            end
            m_head = next_head(m_head, sq_size); m_cnt++;
            total++;
            if (hw_sq_head !== m_head || wqe_processed !== m_cnt || status_word !== exp_status(2'd0)) begin
               bad++; $display("FAIL rand_after: head=%0d cnt=%0d sw=%h want %0d %0d %h",
                               hw_sq_head, wqe_processed, status_word, m_head, m_cnt, exp_status(2'd0));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [71:0] c; int hs; bit st, tmo, hh;
      sq_size = 5'd16;
      sq_tail = m_head + 4'd2;
      run_txn(0, 0, c, hs, st, tmo, hh);
      m_head = m_head + 4'd1; m_cnt++;
      for (int i = 0; i < 20 && !tvalid; i++) step();
      tready = 1'b1;
      step();
      tready = 1'b0;
      step();
      total++;
      if (status_word[9:8] !== 2'd2 || hw_sq_head !== m_head) begin
         bad++; $display("FAIL rstmid_pre: state=%0d head=%0d want 2 %0d", status_word[9:8], hw_sq_head, m_head);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (hw_sq_head !== 4'd0 || tvalid !== 1'b0 || cmd_ctrl_ready !== 1'b1 ||
          wqe_processed !== 32'd0 || status_word[12:10] !== 3'd0) begin
         bad++; $display("FAIL rstmid: head=%0d tvalid=%0b ready=%0b cnt=%0d sticky=%b want 0 0 1 0 000",
                         hw_sq_head, tvalid, cmd_ctrl_ready, wqe_processed, status_word[12:10]);
      end
      m_head = 4'd0; m_cnt = 32'd0; m_cfg = 1'b0; m_spur = 1'b0; m_dm = 1'b0;
      sq_tail = 4'd0; sq_size = 5'd8;
      step();
      rst_n = 1'b1;
      step();
   endtask

`ifdef SQ_FETCH_STS_EN
   task automatic test_dm_err();
      sq_tail = 4'd1;
      for (int i = 0; i < 20 && !tvalid; i++) step();
      tready = 1'b1;
      step();
      tready = 1'b0;
      sts_tdata = 8'h40; sts_tvalid = 1'b1;
      step();
      sts_tvalid = 1'b0; sts_tdata = 8'h00;
      m_dm = 1'b1;
      total++;
      if (status_word !== exp_status(2'd3) || hw_sq_head !== 4'd0 || sts_tready !== 1'b1) begin
         bad++; $display("FAIL dm_err: sw=%h head=%0d tready=%0b want %h 0 1", status_word, hw_sq_head, sts_tready, exp_status(2'd3));
      end
      global_enable = 1'b0;
      step();
      total++;
      if (cmd_ctrl_ready !== 1'b1) begin bad++; $display("FAIL dm_err_exit: ready=%0b want 1", cmd_ctrl_ready); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; global_enable = 1'b0; sq_base = '0; sq_size = 5'd8; sq_tail = '0;
      tready = 1'b0; cmplt = 1'b0;
`ifdef SQ_FETCH_STS_EN
      sts_tdata = '0; sts_tvalid = 1'b0;
`endif
      m_head = '0; m_cnt = '0; m_cfg = 1'b0; m_spur = 1'b0; m_dm = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_back_to_back();
      test_spurious();
      test_cfg_err();
      test_random();
      test_reset_mid();
`ifdef SQ_FETCH_STS_EN
      test_dm_err();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sq_fetch_cmd_gen.md
SQ_FETCH_CMD_GEN -- requirements
Module: sq_fetch_cmd_gen

Interface
REQ-001 SHALL have parameter WQE_BYTES, default 64, meaning bytes per SQ entry and the DataMover BTT.
REQ-002 SHALL have parameter SQ_IDX_W, default 4, meaning width of the head and tail indices.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port global_enable  in  1  CTRL bit 0.
REQ-006 SHALL have port sq_base  in  32  SQ ring byte base address.
REQ-007 SHALL have port sq_size  in  SQ_IDX_W+1  number of ring entries.
REQ-008 SHALL have port sq_tail  in  SQ_IDX_W  software producer index.
REQ-009 SHALL have port hw_sq_head  out  SQ_IDX_W  hardware consumer index.
REQ-010 SHALL have ports m_axis_mm2s_cmd_tdata  out  72, m_axis_mm2s_cmd_tvalid  out  1 and m_axis_mm2s_cmd_tready  in  1, forming the DataMover MM2S command stream.
REQ-011 SHALL have port mm2s_rd_xfer_cmplt  in  1  single-cycle read-done pulse.
REQ-012 SHALL have port cmd_ctrl_ready  out  1  high only in IDLE.
REQ-013 SHALL have port wqe_processed  out  32  completed-entry counter.
REQ-014 SHALL have port status_word  out  32  debug status.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT_CMPLT and CFG_ERR.
REQ-016 SHALL go IDLE->ISSUE on the next edge when all of the following hold: global_enable=1, hw_sq_head!=sq_tail, sq_size in 2..2^SQ_IDX_W, and sq_tail<sq_size.
REQ-017 SHALL go IDLE->CFG_ERR when global_enable=1, hw_sq_head!=sq_tail and either sq_size or sq_tail is invalid; CFG_ERR SHALL be left to IDLE only when global_enable=0.
REQ-018 SHALL assert tvalid in ISSUE, hold tdata stable until tready, and go to WAIT_CMPLT in the cycle after the tvalid&tready handshake.
REQ-019 SHALL form the command as: [22:0] BTT=WQE_BYTES, [23] type=1 (INCR), [29:24] DSA=0, [30] EOF=1, [31] DRR=0, [63:32] address, [67:64] tag=hw_sq_head[3:0], [71:68] reserved=0.
REQ-020 SHALL compute the address as sq_base + hw_sq_head*WQE_BYTES, 32-bit, with overflow discarded.
REQ-021 SHALL, on mm2s_rd_xfer_cmplt in WAIT_CMPLT, register at the next edge: head = (head+1==sq_size) ? 0 : head+1; wqe_processed +1, wrapping at 2^32; state=IDLE.
REQ-022 SHALL ignore mm2s_rd_xfer_cmplt outside WAIT_CMPLT and set the sticky bit spurious_cmplt.
REQ-023 SHALL, when global_enable falls mid-transfer, finish ISSUE/WAIT_CMPLT normally and then issue no new command.
REQ-024 SHALL allow a back-to-back issue from IDLE one cycle after a head update.
REQ-025 SHALL drive status_word as: [3:0] head, [7:4] sq_tail, [9:8] state, [10] cfg_err, [11] spurious_cmplt, [12] dm_err, [15:13] 0, [31:16] wqe_processed[15:0].

Reset
REQ-026 SHALL, on rst_n low, asynchronously set: state=IDLE, hw_sq_head=0, tvalid=0, tdata=0, wqe_processed=0, and all sticky bits 0.
REQ-027 SHALL, under those reset values, have cmd_ctrl_ready=1, so a reset mid-transfer abandons the outstanding command.

Configuration
REQ-028 SHALL, with SQ_FETCH_STS_EN defined, add ports s_axis_mm2s_sts_tdata  in  8, s_axis_mm2s_sts_tvalid  in  1 and s_axis_mm2s_sts_tready  out  1.
REQ-029 SHALL, with SQ_FETCH_STS_EN defined, tie tready=1 and, on an accepted status in WAIT_CMPLT with any of bits [6:4] set, set dm_err, leave the head unchanged, and go to CFG_ERR.
REQ-030 SHALL, without SQ_FETCH_STS_EN, omit the status ports and force dm_err to 0.

Structure
REQ-031 SHALL take from shared package rdma_pkg: the FSM state enum, the command bit-field offsets, the DM_TYPE_INCR constant, and the status_word bit indices.
REQ-032 SHALL use one combinational sub-module, dm_cmd_pack, that maps (addr, btt, tag) to the 72-bit command.

Verification
REQ-033 SHALL cover: base=0x10000000, size=8, tail 0->1, enable=1 -> one command with addr 0x10000000, BTT 64, tag 0; head stays 0 until cmplt, then becomes 1 and wqe_processed becomes 1.
REQ-034 SHALL cover: tready held low 5 cycles -> tvalid and tdata stable for 5 cycles, with exactly one handshake.
REQ-035 SHALL cover: head=7, size=8, tail=0 -> addr 0x100001C0 and, after cmplt, head=0 (wrap).
REQ-036 SHALL cover: a cmplt pulse while IDLE -> head unchanged and status_word[11]=1.
REQ-037 SHALL cover: size=1 with tail!=head -> CFG_ERR, status_word[10]=1, no command issued; enable=0 -> IDLE.
REQ-038 SHALL cover: rst_n low during WAIT_CMPLT -> immediately head=0, tvalid=0, cmd_ctrl_ready=1; with SQ_FETCH_STS_EN, a status of 0x40 -> dm_err=1, head unchanged.
